// File: rtl/class_feature_packer.sv
// Serial-to-parallel front end for the decision-tree classifier: collects N_FEAT bits, waits SETTLE cycles, samples the class.
// Result appears SETTLE+1 cycles after the last beat; s_ready is registered and drops while a result is pending.
module class_feature_packer #(
   parameter int N_FEAT = 51,
   parameter int CLS_W  = 1,
   parameter int SETTLE = 1,
   parameter int FCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_data,
   input  logic              s_last,
   output logic [N_FEAT-1:0] feat_o,
   input  logic [CLS_W-1:0]  cls_i,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CLS_W-1:0]  m_class,
   output logic              err,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_COLLECT,
      ST_DISCARD,
      ST_WAIT,
      ST_OUTPUT
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [SET_W-1:0] settle;
   logic             accept;

   assign accept = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_COLLECT;
         idx       <= '0;
         settle    <= '0;
         feat_o    <= '0;
         m_valid   <= 1'b0;
         m_class   <= '0;
         err       <= 1'b0;
         frame_cnt <= '0;
         s_ready   <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_COLLECT: begin
               s_ready <= 1'b1;
               if (accept) begin
                  feat_o[idx] <= s_data;
                  if (idx == IDX_LAST) begin
                     idx <= '0;
                     if (s_last) begin
                        state   <= ST_WAIT;
                        settle  <= '0;
                        s_ready <= 1'b0;
                     end else begin
                        // Too many beats: flag now, swallow the rest of the frame.
                        err   <= 1'b1;
                        state <= ST_DISCARD;
                     end
                  end else if (s_last) begin
                     err <= 1'b1;
                     idx <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_DISCARD: begin
               s_ready <= 1'b1;
               if (accept && s_last) begin
                  state <= ST_COLLECT;
                  idx   <= '0;
               end
            end
            ST_WAIT: begin
               s_ready <= 1'b0;
               if (settle == SET_LAST) begin
                  m_class <= cls_i;
                  m_valid <= 1'b1;
                  state   <= ST_OUTPUT;
               end else begin
                  settle <= settle + 1'b1;
               end
            end
            ST_OUTPUT: begin
               s_ready <= 1'b0;
               if (m_ready) begin
                  // Reopen the input on the handshake edge so the next frame starts without a bubble.
                  m_valid   <= 1'b0;
                  frame_cnt <= frame_cnt + 1'b1;
                  state     <= ST_COLLECT;
                  idx       <= '0;
                  s_ready   <= 1'b1;
               end
            end
            default: begin
               state   <= ST_COLLECT;
               idx     <= '0;
               s_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_class_feature_packer.sv
// Bench for class_feature_packer: table of frames on a SETTLE=1 instance, random bubbly frames on a SETTLE=3 instance,
// reset corner cases, and frame-counter wrap on a narrow instance.
module tb_class_feature_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Two full-size instances: u=0 uses SETTLE=1, u=1 uses SETTLE=3.
   logic        rst_a [2];
   logic        sv [2];
   logic        sr [2];
   logic        sd [2];
   logic        sl [2];
   logic [50:0] feat [2];
   logic        cls [2];
   logic        mv [2];
   logic        mr [2];
   logic        mc [2];
   logic        er [2];
   logic [15:0] fc [2];

   assign cls[0] = feat[0][10] & feat[0][40];
   assign cls[1] = feat[1][10] & feat[1][40];

   class_feature_packer #(.N_FEAT(51), .CLS_W(1), .SETTLE(1), .FCNT_W(16)) dut (
      .clk(clk), .rst(rst_a[0]), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]), .s_last(sl[0]),
      .feat_o(feat[0]), .cls_i(cls[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_class(mc[0]),
      .err(er[0]), .frame_cnt(fc[0]));

   class_feature_packer #(.N_FEAT(51), .CLS_W(1), .SETTLE(3), .FCNT_W(16)) dut3 (
      .clk(clk), .rst(rst_a[1]), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]), .s_last(sl[1]),
      .feat_o(feat[1]), .cls_i(cls[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_class(mc[1]),
      .err(er[1]), .frame_cnt(fc[1]));

   // Narrow instance so the frame counter wrap is reachable in a short run.
   logic       w_rst, w_valid, w_ready, w_data, w_last, w_mv, w_mc, w_err;
   logic [3:0] w_feat;
   logic [2:0] w_fc;
   logic       w_cls;
   assign w_cls = w_feat[0];

   class_feature_packer #(.N_FEAT(4), .CLS_W(1), .SETTLE(1), .FCNT_W(3)) dutw (
      .clk(clk), .rst(w_rst), .s_valid(w_valid), .s_ready(w_ready), .s_data(w_data), .s_last(w_last),
      .feat_o(w_feat), .cls_i(w_cls), .m_valid(w_mv), .m_ready(1'b1), .m_class(w_mc),
      .err(w_err), .frame_cnt(w_fc));

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_cyc = 0;
   int n_cyc = 0;
   int beat_cyc [64];
   int err_cnt [2] = '{0, 0};
   int err_cyc [2] = '{0, 0};
   int mv_rise [2] = '{0, 0};
   logic mv_prev [2] = '{1'b0, 1'b0};

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled just after each edge.
   always @(posedge clk) begin
      #1;
      for (int u = 0; u < 2; u++) begin
         if (er[u]) begin
            err_cnt[u]++;
            err_cyc[u] = cyc;
            tests++;
            if (mv[u] && !mv_prev[u]) begin
               fails++;
               $display("FAIL err_with_mvalid_rise u=%0d: err=1 m_valid rose, required no overlap", u);
            end
         end
         if (mv[u] && !mv_prev[u]) mv_rise[u]++;
         mv_prev[u] = mv[u];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic send(input int u, input logic [63:0] bits, input int len, input bit with_last,
                       input bit bubble);
      int k = 0;
      int guard = 0;
      while (k < len && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (bubble && $urandom_range(0, 1) == 0) begin
            sv[u] = 1'b0;
         end else begin
            sv[u] = 1'b1;
            sd[u] = bits[k];
            sl[u] = with_last && (k == len - 1);
            if (sr[u]) begin
               beat_cyc[k] = cyc;
               if (k == len - 1) last_cyc = cyc;
               k++;
            end
         end
      end
      if (k < len) begin
         tests++;
         fails++;
         $display("FAIL send_timeout u=%0d: %0d beats accepted, required %0d", u, k, len);
      end
      n_cyc = guard;
      @(negedge clk);
      sv[u] = 1'b0;
      sl[u] = 1'b0;
      sd[u] = 1'b0;
   endtask

   task automatic expect_result(input int u, input logic exp_cls, input logic [50:0] exp_feat,
                                input int settle, input int hold, input int exp_fc);
      int g = 0;
      while (!mv[u] && g < 300) begin
         @(negedge clk);
         g++;
      end
      check("m_valid_seen", 64'(mv[u]), 64'd1);
      check("result_latency", 64'(cyc - last_cyc), 64'(settle + 1));
      check("m_class", 64'(mc[u]), 64'(exp_cls));
      check("feat_o", 64'(feat[u]), 64'(exp_feat));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_m_valid", 64'(mv[u]), 64'd1);
         check("hold_m_class", 64'(mc[u]), 64'(exp_cls));
         check("hold_feat_o", 64'(feat[u]), 64'(exp_feat));
         check("hold_s_ready", 64'(sr[u]), 64'd0);
      end
      mr[u] = 1'b1;
      @(negedge clk);
      mr[u] = 1'b0;
      check("m_valid_drop", 64'(mv[u]), 64'd0);
      check("frame_cnt", 64'(fc[u]), 64'(exp_fc));
   endtask

   task automatic check_zero_outputs(input int u, input string tag);
      check({tag, "_feat_o"}, 64'(feat[u]), 64'd0);
      check({tag, "_m_valid"}, 64'(mv[u]), 64'd0);
      check({tag, "_m_class"}, 64'(mc[u]), 64'd0);
      check({tag, "_err"}, 64'(er[u]), 64'd0);
      check({tag, "_frame_cnt"}, 64'(fc[u]), 64'd0);
      check({tag, "_s_ready"}, 64'(sr[u]), 64'd0);
   endtask

   task automatic pulse_reset(input int u, input string tag);
      rst_a[u] = 1'b1;
      @(negedge clk);
      check_zero_outputs(u, tag);
      rst_a[u] = 1'b0;
      @(negedge clk);
   endtask

   // Reference model: a frame is delivered only when exactly 51 beats arrive; class = f[10] & f[40].
   function automatic logic model_cls(input logic [63:0] v);
      return v[10] & v[40];
   endfunction

   typedef struct {
      logic [63:0] bits;
      int          len;
      bit          exp_err;
      logic        exp_cls;
      int          hold;
   } vec_t;

   initial begin
      vec_t        tbl [7];
      int          fc_model [2];
      int          e0, r0, len, wk, hs, settle;
      bit          prev_hs, bub;
      logic [63:0] v;
      logic        exp_c;

      for (int u = 0; u < 2; u++) begin
         rst_a[u] = 1'b1; sv[u] = 1'b0; sd[u] = 1'b0; sl[u] = 1'b0; mr[u] = 1'b0;
         fc_model[u] = 0;
      end
      w_rst = 1'b1; w_valid = 1'b0; w_data = 1'b0; w_last = 1'b0;

      tbl[0] = '{64'h7FFFFFFFFFFFF, 51, 1'b0, 1'b1, 0};
      tbl[1] = '{(64'd1 << 10) | (64'd1 << 40), 51, 1'b0, 1'b1, 5};
      tbl[2] = '{64'd0, 51, 1'b0, 1'b0, 0};
      tbl[3] = '{64'hFFFFF, 20, 1'b1, 1'b0, 0};
      tbl[4] = '{(64'd1 << 0) | (64'd1 << 10) | (64'd1 << 40), 51, 1'b0, 1'b1, 0};
      tbl[5] = '{64'hFFFFFFFFFFFFFFFF, 60, 1'b1, 1'b0, 0};
      tbl[6] = '{(64'd1 << 10), 51, 1'b0, 1'b0, 2};

      repeat (2) @(negedge clk);
      check_zero_outputs(0, "reset");
      rst_a[0] = 1'b0;
      rst_a[1] = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         e0 = err_cnt[0];
         r0 = mv_rise[0];
         send(0, tbl[i].bits, tbl[i].len, 1'b1, 1'b0);
         if (!tbl[i].exp_err) begin
            fc_model[0]++;
            expect_result(0, tbl[i].exp_cls, tbl[i].bits[50:0], 1, tbl[i].hold, fc_model[0]);
         end else begin
            repeat (4) @(negedge clk);
            check("err_pulses", 64'(err_cnt[0] - e0), 64'd1);
            check("no_m_valid", 64'(mv_rise[0] - r0), 64'd0);
            if (tbl[i].len > 51) begin
               check("long_err_at_beat50", 64'(err_cyc[0] - beat_cyc[50]), 64'd1);
               check("discard_no_stall", 64'(n_cyc), 64'(tbl[i].len));
            end else begin
               check("short_err_timing", 64'(err_cyc[0] - last_cyc), 64'd1);
            end
         end
      end

      // Random frames: bubble-free on u=0, 50% bubbles on u=1, both against the model.
      for (int r = 0; r < 12; r++) begin
         v = {$urandom, $urandom};
         len = 51;
         if (r % 4 == 3) begin
            len = $urandom_range(1, 64);
            if (len == 51) len = 52;
         end
         exp_c = model_cls(v);
         for (int u = 0; u < 2; u++) begin
            settle = (u == 0) ? 1 : 3;
            bub = (u == 1);
            e0 = err_cnt[u];
            r0 = mv_rise[u];
            send(u, v, len, 1'b1, bub);
            if (len == 51) begin
               fc_model[u]++;
               expect_result(u, exp_c, v[50:0], settle, r % 3, fc_model[u]);
            end else begin
               repeat (6) @(negedge clk);
               check("rand_err_pulses", 64'(err_cnt[u] - e0), 64'd1);
               check("rand_no_m_valid", 64'(mv_rise[u] - r0), 64'd0);
            end
         end
      end

      // Reset mid-frame, then during OUTPUT: no err, no delivered result, counter back to 0.
      e0 = err_cnt[0];
      send(0, 64'h7FFFFFFFFFFFF, 30, 1'b0, 1'b0);
      pulse_reset(0, "rst_midframe");
      fc_model[0] = 0;
      send(0, 64'h7FFFFFFFFFFFF, 51, 1'b1, 1'b0);
      for (int g = 0; g < 20 && !mv[0]; g++) @(negedge clk);
      check("pre_rst_m_valid", 64'(mv[0]), 64'd1);
      pulse_reset(0, "rst_output");
      check("rst_no_err", 64'(err_cnt[0] - e0), 64'd0);
      v = (64'd1 << 10) | (64'd1 << 40) | (64'd1 << 50);
      send(0, v, 51, 1'b1, 1'b0);
      fc_model[0]++;
      expect_result(0, model_cls(v), v[50:0], 1, 0, fc_model[0]);

      // Counter wrap on the narrow instance: 8 frames through a 3-bit counter.
      w_rst = 1'b0;
      @(negedge clk);
      wk = 0;
      hs = 0;
      prev_hs = 1'b0;
      for (int c = 0; c < 400 && hs < 8; c++) begin
         @(negedge clk);
         if (prev_hs) begin
            hs++;
            check("wrap_frame_cnt", 64'(w_fc), 64'(hs % 8));
         end
         prev_hs = w_mv;
         w_valid = 1'b1;
         w_data = 1'($urandom_range(0, 1));
         w_last = (wk == 3);
         if (w_ready) wk = (wk + 1) % 4;
      end
      w_valid = 1'b0;
      check("wrap_handshakes", 64'(hs), 64'd8);
      check("wrap_final_zero", 64'(w_fc), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
